lc3_mmio: RTL and testbench
===========================

Name: lc3_mmio

Overview:
- Memory-mapped I/O unit sitting beside lc3_Memory on the LC-3 datapath, downstream of the MAR/MDR path.
- Decodes device-register addresses (xFE00 and above) and implements the keyboard, display and machine-control registers: KBSR, KBDR, DSR, DDR, MCR.
- Returns read data and the R (ready) response to the memory stage.
- Exposes byte-wide valid/ready streams to an external keyboard source and display sink.

Parameters:
- IO_BASE, 16'hFE00, lowest I/O address; is_io = (addr >= IO_BASE).
- KBSR_ADDR, 16'hFE00, keyboard status register.
- KBDR_ADDR, 16'hFE02, keyboard data register.
- DSR_ADDR, 16'hFE04, display status register.
- DDR_ADDR, 16'hFE06, display data register.
- MCR_ADDR, 16'hFFFE, machine control register.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- acc_valid  in  1  access request from the memory stage (MIO_EN qualified); held high until r.
- acc_we  in  1  1 = write, 0 = read (LC-3 R.W).
- acc_addr  in  16  MAR value.
- acc_wdata  in  16  MDR value for writes.
- is_io  out  1  combinational address decode of acc_addr.
- acc_rdata  out  16  read data; valid while r = 1.
- r  out  1  ready; one-cycle pulse completing the access.
- kbd_valid  in  1  keyboard byte available.
- kbd_data  in  8  keyboard byte.
- kbd_ready  out  1  unit can accept a keyboard byte.
- disp_valid  out  1  display byte pending.
- disp_data  out  8  display byte.
- disp_ready  in  1  display consumed the byte.
- run  out  1  MCR[15]; datapath clock-enable.

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge), all values after that edge:
  - KBSR = 16'h0000, KBDR = 16'h0000, DSR = 16'h8000, DDR = 16'h0000, MCR = 16'h8000.
  - FSM = IDLE; r = 0; acc_rdata = 0; disp_valid = 0; kbd_ready = 1; run = 1.
- Access FSM, states IDLE and RESP:
  - IDLE -> RESP when acc_valid && is_io. The register read or write, including side effects, commits on this edge, and acc_rdata is registered on the same edge.
  - RESP: r = 1 for exactly one cycle, then RESP -> IDLE unconditionally. A request still high in RESP is not re-sampled.
  - Latency: r is seen 1 cycle after acc_valid is sampled. Back-to-back accesses complete every 2 cycles.
  - acc_valid with !is_io is ignored: r stays 0.
- Reads:
  - KBSR / DSR / MCR return the full register.
  - KBDR returns {8'h00, byte} and clears KBSR[15].
  - DDR returns the last written value.
  - Any other I/O address returns 16'h0000.
- Writes:
  - KBSR and DSR: only bit 14 (IE) is writable.
  - KBDR: ignored.
  - DDR: if DSR[15] = 1, latch acc_wdata[7:0], clear DSR[15] and set disp_valid. If DSR[15] = 0, the write is dropped.
  - MCR: full 16 bits written; run follows MCR[15].
  - Unmapped I/O address: ignored, but r is still returned.
- Keyboard:
  - kbd_ready = ~KBSR[15] (one-entry buffer).
  - On kbd_valid && kbd_ready: KBDR[7:0] <= kbd_data, KBSR[15] <= 1.
  - A KBDR read in the same cycle as a capture cannot occur, because KBSR[15] = 1 implies kbd_ready = 0.
- Display:
  - disp_valid = ~DSR[15]; disp_data = DDR[7:0].
  - On disp_valid && disp_ready: DSR[15] <= 1.
  - A DDR write and display completion in the same cycle cannot coincide, because the write needs DSR[15] = 1.
- MCR[15] = 0 drives run low. The unit itself keeps running, so I/O completes and R is still returned.
- Reset asserted mid-access (FSM in RESP) aborts the access: r = 0 on the next cycle.

Optional Feature:
- Macro: LC3_MMIO_IRQ_EN.
- With the macro defined:
  - Adds output irq (1 bit) and output irq_vec (8 bits).
  - irq is registered: irq = (KBSR[15] & KBSR[14]) | (DSR[15] & DSR[14]).
  - irq_vec = x80 when the keyboard source is active, otherwise x81; keyboard has priority.
- Without the macro: the ports are absent; IE bits stay readable and writable but have no effect.

Decomposition:
- Package lc3_mmio_pkg holds:
  - address constants;
  - FSM state encoding (IDLE = 1'b0, RESP = 1'b1);
  - bit positions (READY_BIT = 15, IE_BIT = 14);
  - interrupt vectors.
- Sub-module lc3_mmio_fsm is the IDLE/RESP access sequencer, producing the commit strobe and r. Register storage stays in the top.

Test Plan:
- Reset, then read xFE04 and xFFFE -> r pulses 1 cycle after acc_valid; rdata = x8000 for both; kbd_ready = 1, run = 1.
- Drive kbd_valid with x41, then read xFE00 and xFE02 -> KBSR = x8000 and KBDR = x0041; KBSR[15] clears after the read, and kbd_ready returns to 1.
- Write xFE06 = x0048 with disp_ready = 0 -> disp_valid = 1, disp_data = x48, DSR = x0000.
- Then write xFE06 = x0049 -> write dropped, DDR stays x0048.
- Then pulse disp_ready -> DSR = x8000.
- Write xFFFE = x0000 -> run = 0 the cycle after commit; a following read of xFFFE still returns r and rdata = x0000.
- Access x3000 -> is_io = 0, r never asserts.
- With LC3_MMIO_IRQ_EN: write KBSR = x4000, then deliver byte x0D -> irq = 1, irq_vec = x80.
- Assert rst during RESP -> r = 0 next cycle, all registers at their reset values.

Source files
------------

// File: rtl/lc3_mmio_pkg.sv
// lc3_mmio_pkg: address map, access-FSM encoding, register bit positions
// and interrupt vectors shared by the LC-3 memory-mapped I/O unit.
package lc3_mmio_pkg;

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    localparam int READY_BIT = 15;
    localparam int IE_BIT    = 14;

    localparam logic [7:0] KBD_VEC  = 8'h80;
    localparam logic [7:0] DISP_VEC = 8'h81;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } acc_state_e;

endpackage

// File: rtl/lc3_mmio_fsm.sv
// lc3_mmio_fsm: IDLE/RESP access sequencer. Raises commit for the single
// edge on which an I/O access takes effect, then returns r for one cycle.
module lc3_mmio_fsm
    import lc3_mmio_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic acc_valid,
    input  logic is_io,
    output logic commit,
    output logic r
);

    acc_state_e state, state_next;

    // State register; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and strobes; a request held high during RESP is not re-sampled.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        r          = 1'b0;
        case (state)
            IDLE: begin
                if (acc_valid && is_io) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                r          = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/lc3_mmio.sv
// lc3_mmio: LC-3 device registers KBSR/KBDR/DSR/DDR/MCR with keyboard and
// display byte streams. Optional interrupt outputs under LC3_MMIO_IRQ_EN.
module lc3_mmio
    import lc3_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_valid,
    input  logic        acc_we,
    input  logic [15:0] acc_addr,
    input  logic [15:0] acc_wdata,
    output logic        is_io,
    output logic [15:0] acc_rdata,
    output logic        r,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
`ifdef LC3_MMIO_IRQ_EN
    output logic        irq,
    output logic [7:0]  irq_vec,
`endif
    output logic        run
);

    // Only the architecturally meaningful bits of KBSR/DSR/KBDR/DDR are stored.
    logic        kbsr_rdy, kbsr_ie;
    logic        dsr_rdy, dsr_ie;
    logic [7:0]  kbd_byte;
    logic [7:0]  ddr_byte;
    logic [15:0] mcr;
    logic [15:0] rdata_p1;
    logic [15:0] rd_val;
    logic        commit;

    assign is_io      = (acc_addr >= IO_BASE);
    assign kbd_ready  = ~kbsr_rdy;
    assign disp_valid = ~dsr_rdy;
    assign disp_data  = ddr_byte;
    assign run        = mcr[READY_BIT];
    assign acc_rdata  = rdata_p1;

    lc3_mmio_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .is_io     (is_io),
        .commit    (commit),
        .r         (r)
    );

    // Read-data mux over the device-register map; holes read as zero.
    always_comb begin
        rd_val = 16'h0000;
        case (acc_addr)
            KBSR_ADDR: rd_val = {kbsr_rdy, kbsr_ie, 14'h0000};
            KBDR_ADDR: rd_val = {8'h00, kbd_byte};
            DSR_ADDR:  rd_val = {dsr_rdy, dsr_ie, 14'h0000};
            DDR_ADDR:  rd_val = {8'h00, ddr_byte};
            MCR_ADDR:  rd_val = mcr;
            default:   rd_val = 16'h0000;
        endcase
    end

    // Register file: CPU access on commit, plus keyboard capture and display completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            kbsr_rdy <= 1'b0;
            kbsr_ie  <= 1'b0;
            kbd_byte <= 8'h00;
            dsr_rdy  <= 1'b1;
            dsr_ie   <= 1'b0;
            ddr_byte <= 8'h00;
            mcr      <= 16'h8000;
            rdata_p1 <= 16'h0000;
        end else begin
            if (commit) begin
                rdata_p1 <= acc_we ? 16'h0000 : rd_val;
                if (acc_we) begin
                    case (acc_addr)
                        KBSR_ADDR: kbsr_ie <= acc_wdata[IE_BIT];
                        DSR_ADDR:  dsr_ie  <= acc_wdata[IE_BIT];
                        DDR_ADDR: begin
                            if (dsr_rdy) begin
                                ddr_byte <= acc_wdata[7:0];
                                dsr_rdy  <= 1'b0;
                            end
                        end
                        MCR_ADDR:  mcr <= acc_wdata;
                        default: ;
                    endcase
                end else if (acc_addr == KBDR_ADDR) begin
                    kbsr_rdy <= 1'b0;
                end
            end
            // Capture after the read-clear so a simultaneous arrival is never lost.
            if (kbd_valid && kbd_ready) begin
                kbd_byte <= kbd_data;
                kbsr_rdy <= 1'b1;
            end
            if (disp_valid && disp_ready) begin
                dsr_rdy <= 1'b1;
            end
        end
    end

`ifdef LC3_MMIO_IRQ_EN
    // Registered interrupt request; keyboard wins the vector when both are active.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq     <= 1'b0;
            irq_vec <= DISP_VEC;
        end else begin
            irq     <= (kbsr_rdy & kbsr_ie) | (dsr_rdy & dsr_ie);
            irq_vec <= (kbsr_rdy & kbsr_ie) ? KBD_VEC : DISP_VEC;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_mmio.sv
// tb_lc3_mmio: directed bench for lc3_mmio (interrupt checks under LC3_MMIO_IRQ_EN).
module tb_lc3_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_valid, acc_we;
    logic [15:0] acc_addr, acc_wdata;
    logic        is_io;
    logic [15:0] acc_rdata;
    logic        r;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        run;
`ifdef LC3_MMIO_IRQ_EN
    logic        irq;
    logic [7:0]  irq_vec;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lc3_mmio dut (
        .clk        (clk),
        .rst        (rst),
        .acc_valid  (acc_valid),
        .acc_we     (acc_we),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .is_io      (is_io),
        .acc_rdata  (acc_rdata),
        .r          (r),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
`ifdef LC3_MMIO_IRQ_EN
        .irq        (irq),
        .irq_vec    (irq_vec),
`endif
        .run        (run)
    );

    // One access: hold acc_valid until r (bounded), return data and latency (-1 = no r).
    task automatic do_acc(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rd, output int lat);
        acc_we    = we;
        acc_addr  = addr;
        acc_wdata = wdata;
        acc_valid = 1'b1;
        lat       = -1;
        rd        = 16'hxxxx;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (r === 1'b1) begin
                lat = i;
                rd  = acc_rdata;
                break;
            end
        end
        acc_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int lat;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (r !== 1'b0) begin failures++; $display("FAIL reset_r got %b exp 0", r); end
        checks++; if (acc_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got %h exp 0000", acc_rdata); end
        checks++; if (kbd_ready !== 1'b1) begin failures++; $display("FAIL reset_kbd_ready got %b exp 1", kbd_ready); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_disp_valid got %b exp 0", disp_valid); end
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL reset_run got %b exp 1", run); end
`ifdef LC3_MMIO_IRQ_EN
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", irq); end
`endif
        // Single-cycle r pulse: check r one cycle after it is first seen.
        acc_we = 1'b0; acc_addr = 16'hFE04; acc_wdata = 16'h0000; acc_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (r !== 1'b1) begin failures++; $display("FAIL dsr_read_lat r got %b exp 1", r); end
        checks++; if (acc_rdata !== 16'h8000) begin failures++; $display("FAIL dsr_read got %h exp 8000", acc_rdata); end
        acc_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (r !== 1'b0) begin failures++; $display("FAIL r_one_cycle got %b exp 0", r); end
        do_acc(1'b0, 16'hFFFE, 16'h0000, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL mcr_read_lat got %0d exp 1", lat); end
        checks++; if (rd !== 16'h8000) begin failures++; $display("FAIL mcr_read got %h exp 8000", rd); end
    endtask

    task automatic test_keyboard();
        logic [15:0] rd;
        int lat;
        kbd_data = 8'h41; kbd_valid = 1'b1;
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        checks++; if (kbd_ready !== 1'b0) begin failures++; $display("FAIL kbd_full_ready got %b exp 0", kbd_ready); end
        do_acc(1'b0, 16'hFE00, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h8000 || lat !== 1) begin failures++; $display("FAIL kbsr_full got %h lat %0d exp 8000 lat 1", rd, lat); end
        do_acc(1'b0, 16'hFE02, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h0041 || lat !== 1) begin failures++; $display("FAIL kbdr_read got %h lat %0d exp 0041 lat 1", rd, lat); end
        checks++; if (kbd_ready !== 1'b1) begin failures++; $display("FAIL kbd_ready_after_read got %b exp 1", kbd_ready); end
        do_acc(1'b0, 16'hFE00, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL kbsr_cleared got %h exp 0000", rd); end
    endtask

    task automatic test_display();
        logic [15:0] rd;
        int lat;
        disp_ready = 1'b0;
        do_acc(1'b1, 16'hFE06, 16'h0048, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ddr_write_lat got %0d exp 1", lat); end
        checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h48) begin failures++; $display("FAIL disp_out got v=%b d=%h exp v=1 d=48", disp_valid, disp_data); end
        do_acc(1'b0, 16'hFE04, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL dsr_busy got %h exp 0000", rd); end
        do_acc(1'b1, 16'hFE06, 16'h0049, rd, lat);
        do_acc(1'b0, 16'hFE06, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h0048 || disp_data !== 8'h48) begin failures++; $display("FAIL ddr_dropped got %h/%h exp 0048/48", rd, disp_data); end
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL disp_done got %b exp 0", disp_valid); end
        do_acc(1'b0, 16'hFE04, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h8000) begin failures++; $display("FAIL dsr_ready got %h exp 8000", rd); end
    endtask

    task automatic test_mcr();
        logic [15:0] rd;
        int lat;
        do_acc(1'b1, 16'hFFFE, 16'h0000, rd, lat);
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL run_low got %b exp 0", run); end
        do_acc(1'b0, 16'hFFFE, 16'h0000, rd, lat);
        checks++; if (lat !== 1 || rd !== 16'h0000) begin failures++; $display("FAIL mcr_halted_read got %h lat %0d exp 0000 lat 1", rd, lat); end
        do_acc(1'b1, 16'hFFFE, 16'h8000, rd, lat);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL run_high got %b exp 1", run); end
    endtask

    task automatic test_ie_bits();
        logic [15:0] rd;
        int lat;
        do_acc(1'b1, 16'hFE00, 16'hC000, rd, lat);
        do_acc(1'b0, 16'hFE00, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h4000) begin failures++; $display("FAIL kbsr_ie_only got %h exp 4000", rd); end
        do_acc(1'b1, 16'hFE02, 16'h00FF, rd, lat);
        do_acc(1'b0, 16'hFE02, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h0041) begin failures++; $display("FAIL kbdr_write_ignored got %h exp 0041", rd); end
        kbd_data = 8'h0D; kbd_valid = 1'b1;
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        @(posedge clk); #1;
`ifdef LC3_MMIO_IRQ_EN
        checks++; if (irq !== 1'b1 || irq_vec !== 8'h80) begin failures++; $display("FAIL kbd_irq got irq=%b vec=%h exp 1/80", irq, irq_vec); end
`endif
        do_acc(1'b0, 16'hFE02, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h000D) begin failures++; $display("FAIL kbdr_0d got %h exp 000D", rd); end
        do_acc(1'b1, 16'hFE00, 16'h0000, rd, lat);
    endtask

    task automatic test_addr_decode();
        logic [15:0] rd;
        int lat;
        acc_addr = 16'hFDFF; #1;
        checks++; if (is_io !== 1'b0) begin failures++; $display("FAIL is_io_fdff got %b exp 0", is_io); end
        acc_addr = 16'hFE00; #1;
        checks++; if (is_io !== 1'b1) begin failures++; $display("FAIL is_io_fe00 got %b exp 1", is_io); end
        acc_addr = 16'h3000; #1;
        checks++; if (is_io !== 1'b0) begin failures++; $display("FAIL is_io_3000 got %b exp 0", is_io); end
        do_acc(1'b0, 16'h3000, 16'h0000, rd, lat);
        checks++; if (lat !== -1) begin failures++; $display("FAIL non_io_no_r got lat %0d exp none", lat); end
        do_acc(1'b0, 16'hFE10, 16'h0000, rd, lat);
        checks++; if (lat !== 1 || rd !== 16'h0000) begin failures++; $display("FAIL unmapped_read got %h lat %0d exp 0000 lat 1", rd, lat); end
        do_acc(1'b1, 16'hFE10, 16'h1234, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL unmapped_write_lat got %0d exp 1", lat); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        acc_we = 1'b0; acc_addr = 16'hFFFE; acc_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (r === 1'b1) pulses++;
        end
        acc_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (pulses !== 3) begin failures++; $display("FAIL back_to_back got %0d pulses exp 3", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat;
        do_acc(1'b1, 16'hFE06, 16'h0055, rd, lat);
        do_acc(1'b1, 16'hFFFE, 16'h1234, rd, lat);
        acc_we = 1'b0; acc_addr = 16'hFFFE; acc_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (r !== 1'b1 || acc_rdata !== 16'h1234) begin failures++; $display("FAIL pre_abort got r=%b d=%h exp 1/1234", r, acc_rdata); end
        rst = 1'b1; acc_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (r !== 1'b0 || acc_rdata !== 16'h0000) begin failures++; $display("FAIL abort got r=%b d=%h exp 0/0000", r, acc_rdata); end
        checks++; if (disp_valid !== 1'b0 || disp_data !== 8'h00 || run !== 1'b1 || kbd_ready !== 1'b1) begin
            failures++; $display("FAIL abort_outputs got dv=%b dd=%h run=%b kr=%b exp 0/00/1/1", disp_valid, disp_data, run, kbd_ready); end
        do_acc(1'b0, 16'hFFFE, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h8000) begin failures++; $display("FAIL abort_mcr got %h exp 8000", rd); end
        do_acc(1'b0, 16'hFE06, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL abort_ddr got %h exp 0000", rd); end
        do_acc(1'b0, 16'hFE04, 16'h0000, rd, lat);
        checks++; if (rd !== 16'h8000) begin failures++; $display("FAIL abort_dsr got %h exp 8000", rd); end
    endtask

    initial begin
        rst = 1'b1; acc_valid = 1'b0; acc_we = 1'b0; acc_addr = 16'h0000; acc_wdata = 16'h0000;
        kbd_valid = 1'b0; kbd_data = 8'h00; disp_ready = 1'b0;
        test_reset();
        test_keyboard();
        test_display();
        test_mcr();
        test_ie_bits();
        test_addr_decode();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
